// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 adder/subtractor (FTZ, RNE), one operation in flight, fixed 5-cycle latency.
// in_ready only in IDLE; result/flags are held in DONE until out_ready is sampled high.
`timescale 1ns/1ps
module fp_add_seq #(
   parameter int  EXP_W = 8,
   parameter int  MAN_W = 23,
   localparam int FP_W  = 1 + EXP_W + MAN_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FP_W-1:0] op_a,
   input  logic [FP_W-1:0] op_b,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FP_W-1:0] result,
   output logic [3:0]      flags
);
   localparam int SW = MAN_W + 4;   // {hidden, frac, guard, round, sticky}
   localparam int EW = EXP_W + 2;   // signed working exponent, room for carry and underflow
   localparam logic [EXP_W-1:0]        EXP_MAX = '1;
   localparam logic signed [EW-1:0]    EXP_INF = {2'b00, EXP_MAX};
   localparam logic [FP_W-1:0]         QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] frac;
   } fp_t;

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
   state_t state, state_nxt;

   fp_t a_in, b_in, a_q, b_q, x, y;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic spec_hit, spec_q;
   logic [FP_W-1:0] spec_res, spec_res_q;
   logic [3:0]      spec_flg, spec_flg_q;

   logic                 swap;
   logic [EXP_W-1:0]     ediff;
   logic [31:0]          shamt;
   logic [SW-1:0]        ysig, ymask, yal;
   logic                 x_sign_q, eff_sub_q;
   logic signed [EW-1:0] exp_q, norm_exp, nexp_q, rexp;
   logic [SW-1:0]        xs_q, ys_q, norm_sig, nsig_q;
   logic [SW:0]          sum_q;
   logic [31:0]          lz;
   logic                 norm_zero, nzero_q;

   logic [MAN_W:0]   mant;
   logic [MAN_W+1:0] mant_r;
   logic [MAN_W-1:0] rfrac;
   logic             g_bit, r_bit, s_bit, rup, inexact;
   logic [FP_W-1:0]  rres, result_q;
   logic [3:0]       rflg, flags_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_ALIGN;
         S_ALIGN: state_nxt = S_ADD;
         S_ADD:   state_nxt = S_NORM;
         S_NORM:  state_nxt = S_ROUND;
         S_ROUND: state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   // Decode and special-case resolution on the incoming operands
   always_comb begin
      a_in      = op_a;
      b_in      = op_b;
      b_in.sign = op_b[FP_W-1] ^ sub;
      a_zero    = (a_in.exp == '0);
      b_zero    = (b_in.exp == '0);
      a_inf     = (a_in.exp == EXP_MAX) && (a_in.frac == '0);
      b_inf     = (b_in.exp == EXP_MAX) && (b_in.frac == '0);
      a_nan     = (a_in.exp == EXP_MAX) && (a_in.frac != '0);
      b_nan     = (b_in.exp == EXP_MAX) && (b_in.frac != '0);
      a_snan    = a_nan && !a_in.frac[MAN_W-1];
      b_snan    = b_nan && !b_in.frac[MAN_W-1];
      spec_hit  = 1'b1;
      spec_res  = '0;
      spec_flg  = '0;
      if (a_nan || b_nan) begin
         spec_res = QNAN;
         spec_flg = {a_snan | b_snan, 3'b000};
      end else if (a_inf && b_inf && (a_in.sign != b_in.sign)) begin
         spec_res = QNAN;
         spec_flg = 4'b1000;
      end else if (a_inf)             spec_res = a_in;
      else if (b_inf)                 spec_res = b_in;
      else if (a_zero && b_zero)      spec_res = {a_in.sign & b_in.sign, {(FP_W-1){1'b0}}};
      else if (a_zero)                spec_res = b_in;
      else if (b_zero)                spec_res = a_in;
      else                            spec_hit = 1'b0;
   end

   // ALIGN: larger magnitude becomes X, Y shifted right with sticky collection
   always_comb begin
      swap  = (b_q[FP_W-2:0] > a_q[FP_W-2:0]);
      x     = swap ? b_q : a_q;
      y     = swap ? a_q : b_q;
      ediff = x.exp - y.exp;
      shamt = 32'(ediff);
      ysig  = {1'b1, y.frac, 3'b000};
      ymask = '0;
      if (shamt >= 32'(MAN_W + 3)) begin
         yal = {{(SW-1){1'b0}}, 1'b1};
      end else begin
         ymask = ~({SW{1'b1}} << shamt);
         yal   = (ysig >> shamt) | {{(SW-1){1'b0}}, |(ysig & ymask)};
      end
   end

   // NORM: carry right-shift or leading-zero left-shift
   always_comb begin
      lz = '0;
      for (int i = 0; i < SW; i++)
         if (sum_q[i]) lz = 32'(SW - 1 - i);
      norm_zero = (sum_q == '0);
      if (sum_q[SW]) begin
         norm_sig = {sum_q[SW:2], sum_q[1] | sum_q[0]};
         norm_exp = exp_q + EW'(1);
      end else begin
         norm_sig = sum_q[SW-1:0] << lz;
         norm_exp = exp_q - EW'(lz);
      end
   end

   // ROUND: nearest-even, then overflow / flush-to-zero
   always_comb begin
      mant    = nsig_q[SW-1:3];
      g_bit   = nsig_q[2];
      r_bit   = nsig_q[1];
      s_bit   = nsig_q[0];
      rup     = g_bit & (r_bit | s_bit | mant[0]);
      mant_r  = {1'b0, mant} + (MAN_W+2)'(rup);
      inexact = g_bit | r_bit | s_bit;
      rexp    = nexp_q;
      rfrac   = mant_r[MAN_W-1:0];
      if (mant_r[MAN_W+1]) begin
         rexp  = nexp_q + EW'(1);
         rfrac = mant_r[MAN_W:1];
      end
      if (spec_q) begin
         rres = spec_res_q;
         rflg = spec_flg_q;
      end else if (nzero_q) begin
         rres = '0;
         rflg = '0;
      end else if (rexp >= EXP_INF) begin
         rres = {x_sign_q, EXP_MAX, {MAN_W{1'b0}}};
         rflg = 4'b0101;
      end else if (rexp[EW-1] || (rexp == '0)) begin
         rres = {x_sign_q, {(FP_W-1){1'b0}}};
         rflg = 4'b0011;
      end else begin
         rres = {x_sign_q, rexp[EXP_W-1:0], rfrac};
         rflg = {3'b000, inexact};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         spec_flg_q <= '0;
         x_sign_q   <= 1'b0;
         eff_sub_q  <= 1'b0;
         exp_q      <= '0;
         xs_q       <= '0;
         ys_q       <= '0;
         sum_q      <= '0;
         nsig_q     <= '0;
         nexp_q     <= '0;
         nzero_q    <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_q        <= a_in;
               b_q        <= b_in;
               spec_q     <= spec_hit;
               spec_res_q <= spec_res;
               spec_flg_q <= spec_flg;
               flags_q    <= '0;
            end
            S_ALIGN: begin
               x_sign_q  <= x.sign;
               eff_sub_q <= x.sign ^ y.sign;
               exp_q     <= {2'b00, x.exp};
               xs_q      <= {1'b1, x.frac, 3'b000};
               ys_q      <= yal;
            end
            S_ADD:   sum_q <= eff_sub_q ? ({1'b0, xs_q} - {1'b0, ys_q}) : ({1'b0, xs_q} + {1'b0, ys_q});
            S_NORM: begin
               nsig_q  <= norm_sig;
               nexp_q  <= norm_exp;
               nzero_q <= norm_zero;
            end
            S_ROUND: begin
               result_q <= rres;
               flags_q  <= rflg;
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign flags  = flags_q;

endmodule
